// File: rtl/counter_share_arbiter_pkg.sv
// Shared definitions for the counter-sharing arbiter: controller state encoding.
package counter_share_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/counter_share_arbiter_counter.sv
// Up-counter shared by all requesters; clears on reset and holds at all-ones
// so the observed count never rolls back to zero.
module counter_share_arbiter_counter #(
  parameter int Size = 5
) (
  input  logic            clock,
  input  logic            reset,
  output logic [Size-1:0] count
);

  logic [Size-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (r_count != '1) begin
      r_count <= r_count + Size'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/counter_share_arbiter.sv
// Round-robin owner of one shared counter: grants it to a requester, runs it
// to the latched target, pulses done, then rotates priority past the owner.
module counter_share_arbiter
  import counter_share_arbiter_pkg::*;
#(
  parameter int Size       = 5,
  parameter int Requesters = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [Requesters-1:0]        req,
  input  logic [Requesters*Size-1:0]   target,
  output logic [Requesters-1:0]        grant,
  output logic [Requesters-1:0]        done,
  output logic                         busy,
  output logic [Size-1:0]              count
);

  localparam int PtrW = $clog2(Requesters);
  localparam logic [PtrW:0]   NumReq  = (PtrW+1)'(Requesters);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(Requesters - 1);

  state_t                r_state, w_state_next;
  logic [Requesters-1:0] r_grant, w_grant_next;
  logic [PtrW-1:0]       r_ptr, w_ptr_next;
  logic [PtrW-1:0]       r_win, w_win_next;
  logic [Size-1:0]       r_tgt, w_tgt_next;

  logic [Size-1:0]       w_tgt_arr [Requesters];
  logic [Requesters-1:0] w_rot;
  logic [PtrW-1:0]       w_rot_idx;
  logic [PtrW:0]         w_pick_sum;
  logic [PtrW-1:0]       w_pick;
  logic [PtrW-1:0]       w_next_ptr;
  logic                  w_counter_reset;
  logic [Size-1:0]       w_count;

  // Rotate requests so that bit 0 corresponds to the current pointer.
  for (genvar gi = 0; gi < Requesters; gi++) begin : g_rot
    logic [PtrW:0] w_idx_sum;
    assign w_idx_sum   = (PtrW+1)'(gi) + {1'b0, r_ptr};
    assign w_rot[gi]   = (w_idx_sum >= NumReq) ? req[PtrW'(w_idx_sum - NumReq)]
                                               : req[PtrW'(w_idx_sum)];
    assign w_tgt_arr[gi] = target[gi*Size +: Size];
  end

  always_comb begin
    w_rot_idx = '0;
    for (int i = Requesters - 1; i >= 0; i--) begin
      if (w_rot[i]) w_rot_idx = PtrW'(i);
    end
  end

  assign w_pick_sum = {1'b0, w_rot_idx} + {1'b0, r_ptr};
  assign w_pick     = (w_pick_sum >= NumReq) ? PtrW'(w_pick_sum - NumReq)
                                             : PtrW'(w_pick_sum);
  assign w_next_ptr = (r_win == LastIdx) ? '0 : r_win + PtrW'(1);

  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_ptr_next   = r_ptr;
    w_win_next   = r_win;
    w_tgt_next   = r_tgt;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_win_next   = w_pick;
          w_tgt_next   = w_tgt_arr[w_pick];
          w_grant_next = Requesters'(1) << w_pick;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // A dropped request wins over a simultaneous target match.
        if (!req[r_win]) begin
          w_grant_next = '0;
          w_ptr_next   = w_next_ptr;
          w_state_next = ST_IDLE;
        end else if (w_count == r_tgt) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_grant_next = '0;
        w_ptr_next   = w_next_ptr;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_grant_next = '0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
      r_win   <= '0;
      r_tgt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_grant <= w_grant_next;
      r_ptr   <= w_ptr_next;
      r_win   <= w_win_next;
      r_tgt   <= w_tgt_next;
    end
  end

  // Counter runs only in RUN; the block reset also clears it so count reads 0
  // on the cycle right after a reset edge.
  assign w_counter_reset = reset || (r_state != ST_RUN);

  counter_share_arbiter_counter #(
    .Size (Size)
  ) u_counter (
    .clock (clock),
    .reset (w_counter_reset),
    .count (w_count)
  );

  assign grant = r_grant;
  assign done  = (r_state == ST_DONE) ? r_grant : '0;
  assign busy  = (r_state != ST_IDLE);
  assign count = w_count;

endmodule

// File: tb/tb_counter_share_arbiter.sv
// Scoreboard bench: stimulus queues expected grants/completions, a negedge
// monitor pops and compares them whenever the DUT shows a grant or done.
module tb_counter_share_arbiter;

  localparam int Size = 5;
  localparam int N    = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*Size-1:0] target;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic            busy;
  logic [Size-1:0] count;

  counter_share_arbiter #(.Size(Size), .Requesters(N)) dut (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .target (target),
    .grant  (grant),
    .done   (done),
    .busy   (busy),
    .count  (count)
  );

  always #5 clock = ~clock;

  typedef struct { logic [N-1:0] vec; int gap; } gexp_t;
  typedef struct { logic [N-1:0] vec; int lat; } dexp_t;

  gexp_t g_q[$];
  dexp_t d_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_grant_cyc = 0;
  logic [N-1:0] prev_grant = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, got, want, cyc);
    end else begin
      $display("ok   %s: %0d (cycle %0d)", nm, got, cyc);
    end
  endtask

  task automatic set_tgt(input int idx, input int val);
    target[idx*Size +: Size] = Size'(val);
  endtask

  // Monitor: compares each new grant and each done pulse against the queues.
  always @(negedge clock) begin
    if (grant != '0 && prev_grant == '0) begin
      if (g_q.size() == 0) begin
        chk("grant_unexpected", 32'(grant), 32'(0));
      end else begin
        gexp_t e;
        e = g_q.pop_front();
        chk("grant_vec", 32'(grant), 32'(e.vec));
        if (e.gap != 0) chk("grant_gap", cyc - last_grant_cyc, e.gap);
      end
      last_grant_cyc = cyc;
    end
    if (done != '0) begin
      if (d_q.size() == 0) begin
        chk("done_unexpected", 32'(done), 32'(0));
      end else begin
        dexp_t d;
        d = d_q.pop_front();
        chk("done_vec", 32'(done), 32'(d.vec));
        chk("done_latency", cyc - last_grant_cyc, d.lat);
      end
    end
    prev_grant = grant;
  end

  task automatic push_g(input logic [N-1:0] v, input int gap);
    gexp_t e;
    e.vec = v; e.gap = gap;
    g_q.push_back(e);
  endtask

  task automatic push_d(input logic [N-1:0] v, input int lat);
    dexp_t d;
    d.vec = v; d.lat = lat;
    d_q.push_back(d);
  endtask

  task automatic wait_grant(input logic [N-1:0] v);
    bit hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clock);
      if (grant == v) hit = 1;
    end
    if (!hit) chk("wait_grant_timeout", 32'(grant), 32'(v));
  endtask

  task automatic wait_done(input logic [N-1:0] v);
    bit hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clock);
      if (done == v) hit = 1;
    end
    if (!hit) chk("wait_done_timeout", 32'(done), 32'(v));
  endtask

  task automatic wait_count(input int v);
    bit hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clock);
      if (int'(count) == v) hit = 1;
    end
    if (!hit) chk("wait_count_timeout", 32'(count), 32'(v));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    req    = '1;
    target = '0;

    // Reset held for 3 cycles with all requests high.
    repeat (3) @(negedge clock);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done",  32'(done),  0);
    chk("rst_busy",  32'(busy),  0);
    chk("rst_count", 32'(count), 0);
    push_g(4'b0001, 0);
    push_d(4'b0001, 1);          // target 0: done one cycle after grant
    reset = 1'b0;
    wait_grant(4'b0001);
    req = 4'b0001;
    wait_done(4'b0001);
    req = '0;

    // Single run: requester 2, target 7.
    repeat (2) @(negedge clock);
    set_tgt(2, 7);
    push_g(4'b0100, 0);
    push_d(4'b0100, 8);
    req = 4'b0100;
    wait_grant(4'b0100);
    for (int k = 0; k <= 7; k++) begin
      if (k != 0) @(negedge clock);
      chk("run7_count", 32'(count), k);
    end
    wait_done(4'b0100);
    req = '0;
    @(negedge clock);
    chk("run7_busy_after", 32'(busy), 0);

    // Fairness from a fresh pointer: all requesting, target 1.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_tgt(i, 1);
    req = '1;
    push_g(4'b0001, 0);
    push_g(4'b0010, 4);
    push_g(4'b0100, 4);
    push_g(4'b1000, 4);
    push_g(4'b0001, 4);
    repeat (5) push_d('0, 0);
    for (int i = 0; i < 5; i++) d_q[d_q.size()-5+i].vec = N'(1) << (i % N);
    for (int i = 0; i < 5; i++) d_q[d_q.size()-5+i].lat = 2;
    wait_grant(4'b1000);
    wait_grant(4'b0001);
    req = 4'b0001;
    wait_done(4'b0001);
    req = '0;

    // Maximum target on requester 3: count climbs to 31 without wrapping.
    repeat (2) @(negedge clock);
    set_tgt(3, 31);
    push_g(4'b1000, 0);
    push_d(4'b1000, 32);
    req = 4'b1000;
    wait_grant(4'b1000);
    for (int k = 0; k <= 31; k++) begin
      if (k != 0) @(negedge clock);
      if (int'(count) != k) chk("max_count", 32'(count), k);
    end
    chk("max_count_top", 32'(count), 31);
    wait_done(4'b1000);
    chk("max_count_at_done", 32'(count), 31);
    req = '0;
    @(negedge clock);
    chk("max_count_cleared", 32'(count), 0);

    // Abort: requester 1 drops at count 3; requester 2 wins next.
    @(negedge clock);
    set_tgt(1, 10);
    set_tgt(2, 2);
    push_g(4'b0010, 0);
    push_g(4'b0100, 5);
    push_d(4'b0100, 3);
    req = 4'b0110;
    wait_grant(4'b0010);
    wait_count(3);
    req = 4'b0100;
    @(negedge clock);
    chk("abort_grant", 32'(grant), 0);
    chk("abort_busy",  32'(busy),  0);
    chk("abort_done",  32'(done),  0);
    wait_grant(4'b0100);
    set_tgt(2, 20);              // ignored: target latched at grant
    wait_done(4'b0100);
    req = '0;

    // Reset mid-run at count 5: no done, pointer back to 0.
    repeat (2) @(negedge clock);
    set_tgt(0, 10);
    push_g(4'b0001, 0);
    req = 4'b0001;
    wait_grant(4'b0001);
    wait_count(5);
    reset = 1'b1;
    req = '0;
    @(negedge clock);
    chk("midrst_grant", 32'(grant), 0);
    chk("midrst_busy",  32'(busy),  0);
    chk("midrst_done",  32'(done),  0);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_count", 32'(count), 0);
    set_tgt(0, 0);
    set_tgt(3, 0);
    push_g(4'b0001, 0);          // pointer 0 picks 0 over 3
    push_d(4'b0001, 1);
    req = 4'b1001;
    wait_grant(4'b0001);
    wait_done(4'b0001);
    req = '0;

    repeat (4) @(negedge clock);
    chk("grant_queue_empty", g_q.size(), 0);
    chk("done_queue_empty",  d_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
